// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared types, constants and helper functions for the fuzz stimulus sequencer
package fuzz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } fuzz_state_t;

  // Tap masks select bits 31, 21, 1 and 0 (x^32+x^22+x^2+x+1)
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;
  localparam logic [31:0] MISR_TAPS         = 32'h8020_0003;

  // Widest response the fold helper accepts; narrower responses are zero-padded,
  // which leaves the XOR of chunks unchanged.
  localparam int FOLD_MAX_W = 1024;

  // XOR of the response split into 32-bit chunks
  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] y);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
      acc = acc ^ y[i*32 +: 32];
    end
    return acc;
  endfunction

  // Shift left by one, feeding in the parity of the tapped bits
  function automatic logic [31:0] tap_step(input logic [31:0] v, input logic [31:0] taps);
    return {v[30:0], ^(v & taps)};
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return tap_step(l, LFSR_TAPS);
  endfunction

endpackage

// File: rtl/fuzz_stim_sequencer_misr32.sv
// rtl/fuzz_stim_sequencer_misr32.sv - 32-bit MISR folding a wide response word per enabled cycle
import fuzz_pkg::*;

module fuzz_misr32 #(
  parameter int DIN_W = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [31:0]      sig
);

  logic [FOLD_MAX_W-1:0] din_pad;

  // Zero-extend the response so the shared fold helper can take any width up to FOLD_MAX_W
  always_comb begin
    din_pad = '0;
    din_pad[DIN_W-1:0] = din;
  end

  // Signature register: clear wins over enable; enable shifts and absorbs the folded word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= tap_step(sig, MISR_TAPS) ^ fold32(din_pad);
    end
  end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// rtl/fuzz_stim_sequencer.sv - steps a DUT through LFSR vectors and compresses its responses
import fuzz_pkg::*;

module fuzz_stim_sequencer #(
  parameter int IN_W    = 76,
  parameter int OUT_W   = 240,
  parameter int NUM_VEC = 22,
  parameter int SETTLE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [31:0]                seed,
  input  logic [OUT_W-1:0]           dut_y,
  output logic [IN_W-1:0]            stim,
  output logic                       capture,
  output logic [$clog2(NUM_VEC):0]   vec_idx,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                signature
);

  localparam int VW = $clog2(NUM_VEC) + 1;
  localparam int CW = $clog2(SETTLE + 1) + 1;
  localparam logic [VW-1:0] LAST_IDX   = VW'(NUM_VEC - 1);
  localparam logic [CW-1:0] SETTLE_CNT = CW'(SETTLE);

  fuzz_state_t      state, state_nxt;
  logic [31:0]      lfsr;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  lfsr_rep;
  logic             start_ok;
  logic             do_capture;
  logic             last_vec;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides everything including a simultaneous start
  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    do_capture = 1'b0;
    last_vec   = (vec_idx == LAST_IDX);
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt = ST_WAIT;
            start_ok  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          do_capture = 1'b1;
          state_nxt  = last_vec ? ST_DONE : ST_WAIT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // LFSR word replicated across the stimulus bus: {lfsr,lfsr,...} truncated to IN_W
  always_comb begin
    lfsr_rep = '0;
    for (int i = 0; i < IN_W; i++) begin
      lfsr_rep[i] = lfsr[i % 32];
    end
  end

  // Stimulus, vector index, settle counter, LFSR and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stim    <= '0;
      vec_idx <= '0;
      cnt     <= '0;
      lfsr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      capture <= 1'b0;
    end else begin
      busy    <= (state_nxt == ST_WAIT) || (state_nxt == ST_CAPTURE);
      done    <= (state_nxt == ST_DONE);
      capture <= (state_nxt == ST_CAPTURE);
      if (abort && ((state == ST_WAIT) || (state == ST_CAPTURE))) begin
        stim <= '0;
      end else if (start_ok) begin
        lfsr    <= (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
        stim    <= '0;
        vec_idx <= '0;
        cnt     <= SETTLE_CNT;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end else if (do_capture && !last_vec) begin
        vec_idx <= vec_idx + VW'(1);
        stim    <= lfsr_rep;
        lfsr    <= lfsr_step(lfsr);
        cnt     <= SETTLE_CNT;
      end
    end
  end

  fuzz_misr32 #(
    .DIN_W (OUT_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (do_capture),
    .din   (dut_y),
    .sig   (signature)
  );

endmodule

// File: doc/fuzz_stim_sequencer.md
Name: fuzz_stim_sequencer

Overview:
Sequences a generated combinational/sequential DUT (the flattened `top`) through a run of packed input vectors. It drives one IN_W-bit stimulus bus, which the caller splits into wire0..wire4 (76 bits total). It waits a programmable settle time, then compresses the OUT_W-bit `y` response into a 32-bit MISR signature. This replaces per-cycle result dumping for equivalence runs across synthesis tools: only signatures are compared. It sits between the run controller (start/abort/seed) and the DUT.

Parameters:
IN_W, 76, stimulus width, packed {wire0,wire1,wire2,wire3,wire4} (22+6+15+21+12).
OUT_W, 240, DUT response width (`y`).
NUM_VEC, 22, vectors per run including the leading all-zero vector; must be >=1.
SETTLE, 1, extra wait cycles per vector before capture; must be >=0.

Ports:
clk  input  1  clock, all logic on posedge.
rst_n  input  1  synchronous active-low reset.
start  input  1  begin run; accepted only in IDLE or DONE.
abort  input  1  cancel run; effective in any state.
seed  input  32  LFSR seed, sampled on accepted start.
dut_y  input  OUT_W  DUT response.
stim  output  IN_W  stimulus to DUT.
capture  output  1  one-cycle pulse: dut_y is folded into the MISR this cycle.
vec_idx  output  $clog2(NUM_VEC)+1  index of the vector currently applied.
busy  output  1  high in WAIT/CAPTURE.
done  output  1  high in DONE; signature valid.
signature  output  32  MISR state.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. stim, vec_idx, signature and the LFSR reset to 0. busy, done and capture reset to 0.
- States:
  - IDLE -> WAIT on start.
  - WAIT -> CAPTURE when cnt==0; otherwise cnt decrements.
  - CAPTURE -> WAIT (more vectors) or DONE (last vector).
  - DONE -> WAIT on start.
- Start accept (IDLE/DONE, abort=0):
  - lfsr <= (seed==0) ? 32'h1 : seed.
  - stim <= 0; vec_idx <= 0; cnt <= SETTLE; signature <= 0; done <= 0.
- WAIT occupies SETTLE+1 cycles; stim is held stable throughout.
- CAPTURE (1 cycle, capture=1):
  - fold = XOR of dut_y split into 32-bit chunks, top chunk zero-padded.
  - fb = sig[31]^sig[21]^sig[1]^sig[0].
  - sig <= {sig[30:0],fb} ^ fold.
  - If vec_idx==NUM_VEC-1: go to DONE, done=1, stim held.
  - Else: vec_idx++; stim <= {lfsr,lfsr,lfsr}[IN_W-1:0]; lfsr <= step(lfsr); cnt <= SETTLE; go to WAIT.
- LFSR: Fibonacci, x^32+x^22+x^2+x+1, step = {l[30:0], l[31]^l[21]^l[1]^l[0]}.
- Timing: one vector = SETTLE+2 cycles. done rises at the posedge that ends the final CAPTURE, i.e. NUM_VEC*(SETTLE+2) cycles after the start-accept edge.
- abort=1 in WAIT/CAPTURE: next state IDLE; stim <= 0; busy=0; done=0; signature keeps its partial value (not valid). abort in IDLE/DONE: go to/stay in IDLE, done cleared.
- abort and start in the same cycle: abort wins; start is ignored.
- start while busy: ignored.
- Reset mid-run: immediate return to reset values at that edge; no capture occurs.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package fuzz_pkg holds:
  - state enum (IDLE/WAIT/CAPTURE/DONE);
  - LFSR taps constant and default seed 32'h1;
  - MISR taps constant;
  - function fold32(OUT_W) and function lfsr_step.
- One sub-module, fuzz_misr32: fold plus shift register with clear and enable. It is reusable by the response-compare block.

Test Plan:
- Reset with all inputs toggling -> stim=0, signature=0, busy=0, done=0, capture=0 for every cycle rst_n=0.
- NUM_VEC=4, SETTLE=0, seed=0, start pulse -> expected sequence:
  - stim = 0 first;
  - stim = 76'h10000000100000001 at the second vector;
  - capture pulses 4 times at 2-cycle spacing;
  - done=1 exactly 8 cycles after the start edge.
- dut_y tied to 0 across a full run -> signature=32'h0 at done. dut_y=1 at vector 0 only, NUM_VEC=1 -> signature=32'h00000001.
- dut_y = all-ones (240b), NUM_VEC=1 -> fold gives 7 full chunks (ones) plus the 16-bit top chunk, so signature=32'hFFFF0000 (7 odd -> all-ones, XOR 16'hFFFF padded). Check against the reference model.
- abort asserted in the third WAIT cycle -> next cycle IDLE, stim=0, busy=0, done=0. A following start produces the identical signature to an unaborted run with the same seed.
- Edge cases:
  - start+abort in the same cycle -> stays IDLE.
  - start during busy -> ignored; vec_idx continues unchanged.
  - start in DONE -> a new run with signature cleared.
